// File: rtl/dma_desc_sched_pkg.sv
// Shared types for the DMA descriptor scheduler: descriptor/error payloads,
// scheduler state encoding and the default queue depth.
package dma_desc_sched_pkg;

  localparam int DMA_SCHED_DEPTH = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    RUN   = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } dma_sched_st_t;

  typedef enum logic [1:0] {
    DMA_NO_ERR        = 2'd0,
    DMA_UNALIGNED_ERR = 2'd1,
    DMA_BUS_ERR       = 2'd2,
    DMA_LEN_ERR       = 2'd3
  } dma_err_src_t;

  typedef struct packed {
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [31:0] num_bytes;
  } s_dma_desc_t;

  typedef struct packed {
    logic         valid;
    dma_err_src_t src;
    logic [31:0]  addr;
  } s_dma_error_t;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/dma_desc_fifo.sv
// Descriptor FIFO with wrap-bit pointers; flush empties it and drops a same-cycle push.
module dma_desc_fifo
  import dma_desc_sched_pkg::*;
#(
  parameter int DEPTH = DMA_SCHED_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  s_dma_desc_t din,
  output s_dma_desc_t dout,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  s_dma_desc_t  mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A pop frees the slot, so a push while full is accepted alongside it.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= {(AW+1){1'b0}};
      rd_ptr <= {(AW+1){1'b0}};
    end else if (flush) begin
      wr_ptr <= {(AW+1){1'b0}};
      rd_ptr <= {(AW+1){1'b0}};
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/dma_desc_sched.sv
// Descriptor queue and sequencer driving one read and one write streamer.
// Optional DMA_SCHED_BYTE_CNT_EN adds byte_cnt_o (bytes of completed descriptors).
module dma_desc_sched
  import dma_desc_sched_pkg::*;
#(
  parameter int DESC_DEPTH = DMA_SCHED_DEPTH,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              desc_push_i,
  input  s_dma_desc_t       desc_i,
  output logic              desc_full_o,
  input  logic              dma_go_i,
  input  logic              dma_abort_i,
  input  logic              dma_clear_i,
  output s_dma_desc_t       dma_desc_o,
  output logic              rd_valid_o,
  output logic              wr_valid_o,
  input  logic              rd_done_i,
  input  logic              wr_done_i,
  input  s_dma_error_t      rd_err_i,
  input  s_dma_error_t      wr_err_i,
  output logic              stream_flush_o,
  output logic              dma_busy_o,
  output logic              dma_done_o,
  output s_dma_error_t      dma_error_o,
  output logic              err_is_wr_o,
  output logic [CNT_W-1:0]  desc_cnt_o
`ifdef DMA_SCHED_BYTE_CNT_EN
  ,
  output logic [31:0]       byte_cnt_o
`endif
);

  dma_sched_st_t state;
  logic          abort_r;
  logic          rd_seen;
  logic          wr_seen;
  logic          rd_seen_n;
  logic          wr_seen_n;
  logic          both_done;
  logic          err_hit;
  logic          abort_pend;
  logic          fifo_pop;
  logic          fifo_flush;
  logic          fifo_empty;
  logic          complete;
  logic          cnt_clr;
  s_dma_desc_t   fifo_head;
`ifdef DMA_SCHED_BYTE_CNT_EN
  logic [31:0]   complete_bytes;
`endif

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  dma_desc_fifo #(.DEPTH(DESC_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (desc_push_i),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (desc_i),
    .dout  (fifo_head),
    .full  (desc_full_o),
    .empty (fifo_empty)
  );

  // Done tracking, descriptor completion and FIFO pop/flush requests.
  always_comb begin
    abort_pend = abort_r | dma_abort_i;
    rd_seen_n  = rd_seen | rd_done_i;
    wr_seen_n  = wr_seen | wr_done_i;
    both_done  = rd_seen_n & wr_seen_n;
    err_hit    = rd_err_i.valid | wr_err_i.valid;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    complete   = 1'b0;
    cnt_clr    = 1'b0;
    case (state)
      IDLE: fifo_flush = dma_abort_i;
      ISSUE: begin
        if (abort_pend) begin
          fifo_flush = 1'b1;
        end else begin
          fifo_pop = ~fifo_empty;
          complete = ~fifo_empty & (fifo_head.num_bytes == 32'd0);
        end
      end
      RUN: begin
        if (err_hit) begin
          fifo_flush = 1'b1;
        end else begin
          fifo_flush = both_done & abort_pend;
          complete   = both_done;
        end
      end
      DONE, ERR: cnt_clr = dma_clear_i;
      default: fifo_flush = 1'b0;
    endcase
  end

`ifdef DMA_SCHED_BYTE_CNT_EN
  // Zero-length descriptors complete in ISSUE and contribute nothing.
  always_comb begin
    if (state == RUN) complete_bytes = dma_desc_o.num_bytes;
    else              complete_bytes = 32'd0;
  end

  // Saturating byte total of completed descriptors.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          byte_cnt_o <= 32'd0;
    else if (cnt_clr)  byte_cnt_o <= 32'd0;
    else if (complete) byte_cnt_o <= sat_add32(byte_cnt_o, complete_bytes);
  end
`endif

  // Saturating completed-descriptor counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          desc_cnt_o <= {CNT_W{1'b0}};
    else if (cnt_clr)  desc_cnt_o <= {CNT_W{1'b0}};
    else if (complete) desc_cnt_o <= cnt_inc(desc_cnt_o);
  end

  // Scheduler FSM with registered streamer and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      abort_r        <= 1'b0;
      rd_seen        <= 1'b0;
      wr_seen        <= 1'b0;
      dma_desc_o     <= '0;
      rd_valid_o     <= 1'b0;
      wr_valid_o     <= 1'b0;
      stream_flush_o <= 1'b0;
      dma_busy_o     <= 1'b0;
      dma_done_o     <= 1'b0;
      dma_error_o    <= '0;
      err_is_wr_o    <= 1'b0;
    end else begin
      stream_flush_o <= 1'b0;
      case (state)
        IDLE: begin
          if (dma_go_i) begin
            if (fifo_empty || dma_abort_i) begin
              state      <= DONE;
              dma_done_o <= 1'b1;
            end else begin
              state      <= ISSUE;
              dma_busy_o <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (abort_pend || fifo_empty) begin
            state      <= DONE;
            dma_busy_o <= 1'b0;
            dma_done_o <= 1'b1;
            abort_r    <= 1'b0;
          end else begin
            dma_desc_o <= fifo_head;
            // Zero-length descriptors are retired here without launching streamers.
            if (fifo_head.num_bytes != 32'd0) begin
              state      <= RUN;
              rd_valid_o <= 1'b1;
              wr_valid_o <= 1'b1;
              rd_seen    <= 1'b0;
              wr_seen    <= 1'b0;
            end
          end
        end
        RUN: begin
          if (err_hit) begin
            state          <= ERR;
            dma_busy_o     <= 1'b0;
            rd_valid_o     <= 1'b0;
            wr_valid_o     <= 1'b0;
            stream_flush_o <= 1'b1;
            abort_r        <= 1'b0;
            rd_seen        <= 1'b0;
            wr_seen        <= 1'b0;
            if (rd_err_i.valid) begin
              dma_error_o <= rd_err_i;
              err_is_wr_o <= 1'b0;
            end else begin
              dma_error_o <= wr_err_i;
              err_is_wr_o <= 1'b1;
            end
          end else if (both_done) begin
            rd_valid_o <= 1'b0;
            wr_valid_o <= 1'b0;
            rd_seen    <= 1'b0;
            wr_seen    <= 1'b0;
            if (abort_pend || fifo_empty) begin
              state      <= DONE;
              dma_busy_o <= 1'b0;
              dma_done_o <= 1'b1;
              abort_r    <= 1'b0;
            end else begin
              state <= ISSUE;
            end
          end else begin
            rd_seen <= rd_seen_n;
            wr_seen <= wr_seen_n;
            abort_r <= abort_pend;
          end
        end
        DONE, ERR: begin
          if (dma_clear_i) begin
            state       <= IDLE;
            dma_done_o  <= 1'b0;
            dma_error_o <= '0;
            err_is_wr_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_desc_sched.sv
// Directed self-checking bench for dma_desc_sched with hand-computed expectations.
module tb_dma_desc_sched;
  import dma_desc_sched_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         desc_push_i;
  s_dma_desc_t  desc_i;
  logic         desc_full_o;
  logic         dma_go_i, dma_abort_i, dma_clear_i;
  s_dma_desc_t  dma_desc_o;
  logic         rd_valid_o, wr_valid_o;
  logic         rd_done_i, wr_done_i;
  s_dma_error_t rd_err_i, wr_err_i;
  logic         stream_flush_o, dma_busy_o, dma_done_o;
  s_dma_error_t dma_error_o;
  logic         err_is_wr_o;
  logic [15:0]  desc_cnt_o;
`ifdef DMA_SCHED_BYTE_CNT_EN
  logic [31:0]  byte_cnt_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  dma_desc_sched #(.DESC_DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .desc_push_i(desc_push_i), .desc_i(desc_i), .desc_full_o(desc_full_o),
    .dma_go_i(dma_go_i), .dma_abort_i(dma_abort_i), .dma_clear_i(dma_clear_i), .dma_desc_o(dma_desc_o),
    .rd_valid_o(rd_valid_o), .wr_valid_o(wr_valid_o), .rd_done_i(rd_done_i), .wr_done_i(wr_done_i),
    .rd_err_i(rd_err_i), .wr_err_i(wr_err_i), .stream_flush_o(stream_flush_o), .dma_busy_o(dma_busy_o),
    .dma_done_o(dma_done_o), .dma_error_o(dma_error_o), .err_is_wr_o(err_is_wr_o), .desc_cnt_o(desc_cnt_o)
`ifdef DMA_SCHED_BYTE_CNT_EN
    , .byte_cnt_o(byte_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_desc(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] nb);
    desc_push_i = 1'b1;
    desc_i.src_addr = src; desc_i.dst_addr = dst; desc_i.num_bytes = nb;
    cyc(1);
    desc_push_i = 1'b0;
  endtask

  task automatic go;
    dma_go_i = 1'b1; cyc(1); dma_go_i = 1'b0;
  endtask

  task automatic clear;
    dma_clear_i = 1'b1; cyc(1); dma_clear_i = 1'b0;
  endtask

  task automatic both_dones;
    rd_done_i = 1'b1; wr_done_i = 1'b1; cyc(1); rd_done_i = 1'b0; wr_done_i = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    cyc(3);
    n_checks++; if ({rd_valid_o, wr_valid_o, dma_busy_o, dma_done_o, stream_flush_o, desc_full_o, err_is_wr_o} !== 7'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 0", {rd_valid_o, wr_valid_o, dma_busy_o, dma_done_o, stream_flush_o, desc_full_o, err_is_wr_o}); end
    n_checks++; if (desc_cnt_o !== 16'd0 || dma_error_o !== '0 || dma_desc_o !== '0) begin n_fail++; $display("FAIL reset_regs: cnt %0h err %0h desc %0h expected 0", desc_cnt_o, dma_error_o, dma_desc_o); end
    rst = 1'b1;
    cyc(1);
  endtask

  task automatic test_two_desc;
    push_desc(32'h1000, 32'h8000, 32'd256);
    push_desc(32'h2000, 32'h9000, 32'd64);
    go;
    n_checks++; if (rd_valid_o !== 1'b0 || wr_valid_o !== 1'b0 || dma_busy_o !== 1'b1) begin n_fail++; $display("FAIL two_issue: valids %b%b busy %b expected 00 1", rd_valid_o, wr_valid_o, dma_busy_o); end
    cyc(1);
    n_checks++; if (rd_valid_o !== 1'b1 || wr_valid_o !== 1'b1) begin n_fail++; $display("FAIL two_run1_valid: got %b%b expected 11", rd_valid_o, wr_valid_o); end
    n_checks++; if (dma_desc_o.src_addr !== 32'h1000 || dma_desc_o.dst_addr !== 32'h8000 || dma_desc_o.num_bytes !== 32'd256) begin n_fail++; $display("FAIL two_run1_desc: got %0h/%0h/%0d expected 1000/8000/256", dma_desc_o.src_addr, dma_desc_o.dst_addr, dma_desc_o.num_bytes); end
    rd_done_i = 1'b1; cyc(1); rd_done_i = 1'b0;
    cyc(2);
    n_checks++; if (rd_valid_o !== 1'b1 || wr_valid_o !== 1'b1 || desc_cnt_o !== 16'd0) begin n_fail++; $display("FAIL two_rd_only: valids %b%b cnt %0d expected 11 0", rd_valid_o, wr_valid_o, desc_cnt_o); end
    wr_done_i = 1'b1; cyc(1); wr_done_i = 1'b0;
    n_checks++; if (rd_valid_o !== 1'b0 || wr_valid_o !== 1'b0 || desc_cnt_o !== 16'd1) begin n_fail++; $display("FAIL two_boundary: valids %b%b cnt %0d expected 00 1", rd_valid_o, wr_valid_o, desc_cnt_o); end
    cyc(1);
    n_checks++; if (rd_valid_o !== 1'b1 || dma_desc_o.num_bytes !== 32'd64 || dma_desc_o.src_addr !== 32'h2000) begin n_fail++; $display("FAIL two_run2: valid %b bytes %0d src %0h expected 1 64 2000", rd_valid_o, dma_desc_o.num_bytes, dma_desc_o.src_addr); end
    both_dones;
    n_checks++; if (dma_done_o !== 1'b1 || dma_busy_o !== 1'b0 || desc_cnt_o !== 16'd2 || rd_valid_o !== 1'b0) begin n_fail++; $display("FAIL two_done: done %b busy %b cnt %0d valid %b expected 1 0 2 0", dma_done_o, dma_busy_o, desc_cnt_o, rd_valid_o); end
    cyc(2);
    n_checks++; if (dma_done_o !== 1'b1 || desc_cnt_o !== 16'd2) begin n_fail++; $display("FAIL two_done_hold: done %b cnt %0d expected 1 2", dma_done_o, desc_cnt_o); end
    clear;
    n_checks++; if (dma_done_o !== 1'b0 || desc_cnt_o !== 16'd0) begin n_fail++; $display("FAIL two_clear: done %b cnt %0d expected 0 0", dma_done_o, desc_cnt_o); end
  endtask

  task automatic test_zero_len;
    push_desc(32'h3000, 32'hA000, 32'd128);
    push_desc(32'h3100, 32'hA100, 32'd0);
    push_desc(32'h3200, 32'hA200, 32'd128);
    go; cyc(1);
    both_dones;
    n_checks++; if (desc_cnt_o !== 16'd1 || rd_valid_o !== 1'b0) begin n_fail++; $display("FAIL zero_first: cnt %0d valid %b expected 1 0", desc_cnt_o, rd_valid_o); end
    cyc(1);
    n_checks++; if (rd_valid_o !== 1'b0 || wr_valid_o !== 1'b0 || desc_cnt_o !== 16'd2) begin n_fail++; $display("FAIL zero_skip: valids %b%b cnt %0d expected 00 2", rd_valid_o, wr_valid_o, desc_cnt_o); end
    cyc(1);
    n_checks++; if (rd_valid_o !== 1'b1 || dma_desc_o.src_addr !== 32'h3200 || desc_cnt_o !== 16'd2) begin n_fail++; $display("FAIL zero_third: valid %b src %0h cnt %0d expected 1 3200 2", rd_valid_o, dma_desc_o.src_addr, desc_cnt_o); end
    both_dones;
    n_checks++; if (dma_done_o !== 1'b1 || desc_cnt_o !== 16'd3) begin n_fail++; $display("FAIL zero_done: done %b cnt %0d expected 1 3", dma_done_o, desc_cnt_o); end
    clear;
  endtask

  task automatic test_error;
    push_desc(32'h1000, 32'h8000, 32'd256);
    push_desc(32'h1100, 32'h8100, 32'd64);
    go; cyc(1);
    wr_err_i.valid = 1'b1; wr_err_i.src = DMA_UNALIGNED_ERR; wr_err_i.addr = 32'h1004;
    cyc(1);
    wr_err_i = '0;
    n_checks++; if (stream_flush_o !== 1'b1 || rd_valid_o !== 1'b0 || wr_valid_o !== 1'b0 || dma_busy_o !== 1'b0) begin n_fail++; $display("FAIL err_entry: flush %b valids %b%b busy %b expected 1 00 0", stream_flush_o, rd_valid_o, wr_valid_o, dma_busy_o); end
    n_checks++; if (err_is_wr_o !== 1'b1 || dma_error_o.addr !== 32'h1004 || dma_error_o.src !== DMA_UNALIGNED_ERR || dma_error_o.valid !== 1'b1) begin n_fail++; $display("FAIL err_latch: is_wr %b addr %0h src %0d valid %b expected 1 1004 1 1", err_is_wr_o, dma_error_o.addr, dma_error_o.src, dma_error_o.valid); end
    cyc(1);
    n_checks++; if (stream_flush_o !== 1'b0 || dma_error_o.addr !== 32'h1004 || dma_done_o !== 1'b0) begin n_fail++; $display("FAIL err_hold: flush %b addr %0h done %b expected 0 1004 0", stream_flush_o, dma_error_o.addr, dma_done_o); end
    clear;
    n_checks++; if (dma_error_o !== '0 || err_is_wr_o !== 1'b0) begin n_fail++; $display("FAIL err_clear: err %0h is_wr %b expected 0 0", dma_error_o, err_is_wr_o); end
    go;
    n_checks++; if (dma_done_o !== 1'b1 || dma_busy_o !== 1'b0 || desc_cnt_o !== 16'd0) begin n_fail++; $display("FAIL err_flushed: done %b busy %b cnt %0d expected 1 0 0", dma_done_o, dma_busy_o, desc_cnt_o); end
    clear;
    push_desc(32'h2000, 32'h9000, 32'd32);
    go; cyc(1);
    rd_err_i.valid = 1'b1; rd_err_i.src = DMA_BUS_ERR; rd_err_i.addr = 32'h2000;
    wr_err_i.valid = 1'b1; wr_err_i.src = DMA_LEN_ERR; wr_err_i.addr = 32'h9000;
    cyc(1);
    rd_err_i = '0; wr_err_i = '0;
    n_checks++; if (err_is_wr_o !== 1'b0 || dma_error_o.addr !== 32'h2000 || dma_error_o.src !== DMA_BUS_ERR) begin n_fail++; $display("FAIL err_rd_wins: is_wr %b addr %0h src %0d expected 0 2000 2", err_is_wr_o, dma_error_o.addr, dma_error_o.src); end
    clear;
  endtask

  task automatic test_full;
    logic [31:0] exp_nb [4];
    exp_nb[0] = 32'd32; exp_nb[1] = 32'd48; exp_nb[2] = 32'd80; exp_nb[3] = 32'd112;
    push_desc(32'h10, 32'h20, 32'd16);
    push_desc(32'h11, 32'h21, 32'd32);
    push_desc(32'h12, 32'h22, 32'd48);
    n_checks++; if (desc_full_o !== 1'b0) begin n_fail++; $display("FAIL full_three: got %b expected 0", desc_full_o); end
    push_desc(32'h13, 32'h23, 32'd80);
    n_checks++; if (desc_full_o !== 1'b1) begin n_fail++; $display("FAIL full_four: got %b expected 1", desc_full_o); end
    push_desc(32'h14, 32'h24, 32'd999);
    n_checks++; if (desc_full_o !== 1'b1) begin n_fail++; $display("FAIL full_drop: got %b expected 1", desc_full_o); end
    go;
    push_desc(32'h15, 32'h25, 32'd112);
    n_checks++; if (desc_full_o !== 1'b1 || rd_valid_o !== 1'b1 || dma_desc_o.num_bytes !== 32'd16) begin n_fail++; $display("FAIL full_poppush: full %b valid %b bytes %0d expected 1 1 16", desc_full_o, rd_valid_o, dma_desc_o.num_bytes); end
    for (int i = 0; i < 4; i++) begin
      both_dones;
      cyc(1);
      n_checks++; if (rd_valid_o !== 1'b1 || dma_desc_o.num_bytes !== exp_nb[i]) begin n_fail++; $display("FAIL full_order%0d: valid %b bytes %0d expected 1 %0d", i, rd_valid_o, dma_desc_o.num_bytes, exp_nb[i]); end
    end
    both_dones;
    n_checks++; if (dma_done_o !== 1'b1 || desc_cnt_o !== 16'd5 || desc_full_o !== 1'b0) begin n_fail++; $display("FAIL full_done: done %b cnt %0d full %b expected 1 5 0", dma_done_o, desc_cnt_o, desc_full_o); end
    clear;
  endtask

  task automatic test_abort;
    push_desc(32'h100, 32'h200, 32'd100);
    push_desc(32'h101, 32'h201, 32'd200);
    push_desc(32'h102, 32'h202, 32'd300);
    go; cyc(1);
    dma_abort_i = 1'b1; cyc(1); dma_abort_i = 1'b0;
    n_checks++; if (rd_valid_o !== 1'b1 || dma_desc_o.num_bytes !== 32'd100) begin n_fail++; $display("FAIL abort_cont: valid %b bytes %0d expected 1 100", rd_valid_o, dma_desc_o.num_bytes); end
    both_dones;
    n_checks++; if (dma_done_o !== 1'b1 || desc_cnt_o !== 16'd1 || rd_valid_o !== 1'b0) begin n_fail++; $display("FAIL abort_done: done %b cnt %0d valid %b expected 1 1 0", dma_done_o, desc_cnt_o, rd_valid_o); end
    clear;
    go;
    n_checks++; if (dma_done_o !== 1'b1 || dma_busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_flushed: done %b busy %b expected 1 0", dma_done_o, dma_busy_o); end
    clear;
  endtask

  task automatic test_reset_mid_run;
    push_desc(32'h500, 32'h600, 32'd256);
    go; cyc(1);
    n_checks++; if (rd_valid_o !== 1'b1 || dma_busy_o !== 1'b1) begin n_fail++; $display("FAIL rstrun_pre: valid %b busy %b expected 1 1", rd_valid_o, dma_busy_o); end
    #3 rst = 1'b0;
    #1;
    n_checks++; if ({rd_valid_o, wr_valid_o, dma_busy_o, dma_done_o} !== 4'b0 || dma_desc_o !== '0) begin n_fail++; $display("FAIL rstrun_async: flags %b desc %0h expected 0 0", {rd_valid_o, wr_valid_o, dma_busy_o, dma_done_o}, dma_desc_o); end
    cyc(1);
    rst = 1'b1;
    cyc(1);
    push_desc(32'h700, 32'h800, 32'd72);
    go;
    n_checks++; if (rd_valid_o !== 1'b0 || dma_busy_o !== 1'b1) begin n_fail++; $display("FAIL rstrun_issue: valid %b busy %b expected 0 1", rd_valid_o, dma_busy_o); end
    cyc(1);
    n_checks++; if (rd_valid_o !== 1'b1 || dma_desc_o.num_bytes !== 32'd72 || dma_desc_o.src_addr !== 32'h700) begin n_fail++; $display("FAIL rstrun_restart: valid %b bytes %0d src %0h expected 1 72 700", rd_valid_o, dma_desc_o.num_bytes, dma_desc_o.src_addr); end
    both_dones;
    n_checks++; if (dma_done_o !== 1'b1 || desc_cnt_o !== 16'd1) begin n_fail++; $display("FAIL rstrun_done: done %b cnt %0d expected 1 1", dma_done_o, desc_cnt_o); end
    clear;
  endtask

  initial begin
    rst = 1'b0; desc_push_i = 1'b0; desc_i = '0;
    dma_go_i = 1'b0; dma_abort_i = 1'b0; dma_clear_i = 1'b0;
    rd_done_i = 1'b0; wr_done_i = 1'b0; rd_err_i = '0; wr_err_i = '0;
    #1;
    test_reset;
    test_two_desc;
    test_zero_len;
    test_error;
    test_full;
    test_abort;
    test_reset_mid_run;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
